// File: rtl/pea_result_drain.sv
// Drains paired result/status words from the PEA output FIFOs onto a valid/ready stream.
// Optional macro PEA_DRAIN_ERRCNT_EN adds err_count for records whose status bit 0 is set.
module pea_result_drain #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned POP_W     = 5,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DESYNC_TO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POP_W-1:0] result_pop,
    input  logic [POP_W-1:0] status_pop,
    input  logic [WIDTH-1:0] result_data,
    input  logic [WIDTH-1:0] status_data,
    output logic             rd_en_result,
    output logic             rd_en_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_status,
    output logic [CNT_W-1:0] drain_count,
`ifdef PEA_DRAIN_ERRCNT_EN
    output logic [CNT_W-1:0] err_count,
`endif
    output logic             desync,
    output logic             busy
);

    localparam int unsigned TO_W = $clog2(DESYNC_TO + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StLatch,
        StValid
    } state_e;

    state_e           state_q, state_d;
    logic             rd_en_q, rd_en_d;
    logic [WIDTH-1:0] result_q, status_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             desync_q, desync_d;
    logic             capture;
    logic             accept;
    logic             both_avail;
    logic             mismatch;

    assign both_avail = (result_pop != '0) && (status_pop != '0);
    assign mismatch   = (result_pop == '0) != (status_pop == '0);

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (both_avail && !desync_q) begin
                    state_d = StRead;
                    // rd_en is registered so it is high exactly while in StRead
                    rd_en_d = 1'b1;
                end
            end
            StRead: state_d = StLatch;
            StLatch: begin
                capture = 1'b1;
                state_d = StValid;
            end
            StValid: begin
                if (out_ready) begin
                    accept  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Desync timer counts only in idle; desync asserts on the DESYNC_TO-th mismatched cycle
    always_comb begin
        to_cnt_d = to_cnt_q;
        desync_d = desync_q;
        if (state_q != StIdle || !mismatch) begin
            to_cnt_d = '0;
        end else if (!desync_q) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_W'(DESYNC_TO - 1)) begin
                desync_d = 1'b1;
            end
        end
    end

    assign count_d = accept ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rd_en_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            count_q  <= '0;
            to_cnt_q <= '0;
            desync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            count_q  <= count_d;
            to_cnt_q <= to_cnt_d;
            desync_q <= desync_d;
            if (capture) begin
                result_q <= result_data;
                status_q <= status_data;
            end
        end
    end

`ifdef PEA_DRAIN_ERRCNT_EN
    logic [CNT_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (accept && status_q[0]) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`endif

    assign rd_en_result = rd_en_q;
    assign rd_en_status = rd_en_q;
    assign out_valid    = (state_q == StValid);
    assign out_result   = result_q;
    assign out_status   = status_q;
    assign drain_count  = count_q;
    assign desync       = desync_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pea_result_drain.sv
// Directed bench for pea_result_drain with a small FIFO model feeding the DUT.
module tb_pea_result_drain;

    localparam int WIDTH     = 32;
    localparam int POP_W     = 5;
    localparam int CNT_W     = 16;
    localparam int DESYNC_TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [POP_W-1:0] result_pop, status_pop;
    logic [WIDTH-1:0] result_data = '0;
    logic [WIDTH-1:0] status_data = '0;
    logic             rd_en_result, rd_en_status;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result, out_status;
    logic [CNT_W-1:0] drain_count;
`ifdef PEA_DRAIN_ERRCNT_EN
    logic [CNT_W-1:0] err_count;
`endif
    logic             desync, busy;

    pea_result_drain #(
        .WIDTH    (WIDTH),
        .POP_W    (POP_W),
        .CNT_W    (CNT_W),
        .DESYNC_TO(DESYNC_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .result_pop  (result_pop),
        .status_pop  (status_pop),
        .result_data (result_data),
        .status_data (status_data),
        .rd_en_result(rd_en_result),
        .rd_en_status(rd_en_status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_status  (out_status),
        .drain_count (drain_count),
`ifdef PEA_DRAIN_ERRCNT_EN
        .err_count   (err_count),
`endif
        .desync      (desync),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO model: pushes from the stimulus process, pops on rd_en with one-cycle read latency
    logic [WIDTH-1:0] rmem[64];
    logic [WIDTH-1:0] smem[64];
    int               rwr = 0;
    int               swr = 0;
    int               rd = 0;
    int               pops = 0;
    bit               viol = 0;
    bit               man = 0;
    logic [POP_W-1:0] man_r = '0;
    logic [POP_W-1:0] man_s = '0;

    assign result_pop = man ? man_r : POP_W'(rwr - rd);
    assign status_pop = man ? man_s : POP_W'(swr - rd);

    always @(posedge clk) begin
        if (rd_en_result !== rd_en_status) viol <= 1'b1;
        if (rd_en_result === 1'b1) begin
            if (result_pop == '0 || status_pop == '0) viol <= 1'b1;
            result_data <= rmem[rd % 64];
            status_data <= smem[rd % 64];
            rd          <= rd + 1;
            pops        <= pops + 1;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] st;
    } rec_t;

    rec_t tbl[3];
    rec_t etbl[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] st);
        rmem[rwr % 64] = res;
        smem[swr % 64] = st;
        rwr++;
        swr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, out_valid, 1);
    endtask

    initial begin
        int  p0;
        bit  flag;
        logic [WIDTH-1:0] r0, s0;

        tbl[0] = '{res: 32'h0000_1111, st: 32'h0000_0010};
        tbl[1] = '{res: 32'hDEAD_BEEF, st: 32'h0000_0020};
        tbl[2] = '{res: 32'h8000_0001, st: 32'hFFFF_FFFE};
        etbl[0] = '{res: 32'h0000_00A1, st: 32'h0000_0001};
        etbl[1] = '{res: 32'h0000_00A2, st: 32'h0000_0000};
        etbl[2] = '{res: 32'h0000_00A3, st: 32'h0000_0003};

        rst       = 1'b1;
        out_ready = 1'b0;
        #1;

        // Reset state, then idle with empty FIFOs and stray out_ready
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_en", {rd_en_result, rd_en_status}, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_status", out_status, 0);
        check("rst_drain_count", drain_count, 0);
        check("rst_desync", desync, 0);
        check("rst_busy", busy, 0);
`ifdef PEA_DRAIN_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        out_ready = 1'b1;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_en_result || busy || out_valid || drain_count != 0) flag = 1;
        end
        check("idle_quiet", flag, 0);

        // Single record, cycle-exact latency
        push(32'h0000_00C8, 32'h0000_0002);
        p0 = pops;
        tick();
        check("one_rd_en_hi", {rd_en_result, rd_en_status}, 2'b11);
        check("one_busy", busy, 1);
        tick();
        check("one_rd_en_lo", {rd_en_result, rd_en_status}, 0);
        check("one_not_valid_yet", out_valid, 0);
        tick();
        check("one_valid", out_valid, 1);
        check("one_result", out_result, 32'h0000_00C8);
        check("one_status", out_status, 32'h0000_0002);
        tick();
        check("one_done_valid", out_valid, 0);
        check("one_drain_count", drain_count, 1);
        check("one_pops", pops - p0, 1);

        // Three queued records with a 10-cycle consumer stall
        do_reset();
        out_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 3; i++) push(tbl[i].res, tbl[i].st);
        wait_valid("stall_first_valid");
        r0 = out_result;
        s0 = out_status;
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_result !== r0 || out_status !== s0) flag = 1;
        end
        check("stall_stable", flag, 0);
        check("stall_no_pop", pops - p0, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid("q_valid");
            check("q_result", out_result, tbl[i].res);
            check("q_status", out_status, tbl[i].st);
            tick();
        end
        tick();
        tick();
        check("q_drain_count", drain_count, 3);
        check("q_pops", pops - p0, 3);
        check("q_idle", busy, 0);

        // Desync: one FIFO non-empty, the other empty
        do_reset();
        man   = 1;
        man_r = 5'd1;
        man_s = 5'd0;
        flag  = 0;
        for (int i = 0; i < DESYNC_TO - 1; i++) begin
            tick();
            if (desync || rd_en_result) flag = 1;
        end
        check("desync_early", flag, 0);
        tick();
        check("desync_set", desync, 1);
        man_s = 5'd1;
        flag  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_en_result || rd_en_status || busy || !desync) flag = 1;
        end
        check("desync_blocks", flag, 0);
        do_reset();
        check("desync_cleared", desync, 0);
        man = 0;

        // Reset while holding a record in VALID
        out_ready = 1'b1;
        push(32'h0000_0055, 32'h0000_0000);
        wait_valid("r5_first_valid");
        tick();
        check("r5_drain_pre", drain_count, 1);
        out_ready = 1'b0;
        push(32'h0000_0066, 32'h0000_0004);
        wait_valid("r5_second_valid");
        rst = 1'b1;
        tick();
        check("r5_valid_dropped", out_valid, 0);
        check("r5_drain_zero", drain_count, 0);
        check("r5_idle", busy, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("r5_stay_idle", {busy, rd_en_result}, 0);

`ifdef PEA_DRAIN_ERRCNT_EN
        // Error counting on status bit 0
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(etbl[i].res, etbl[i].st);
        for (int i = 0; i < 3; i++) begin
            wait_valid("e_valid");
            check("e_status", out_status, etbl[i].st);
            tick();
        end
        check("e_err_count", err_count, 2);
        check("e_drain_count", drain_count, 3);
`endif

        check("no_empty_pop", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
